// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
// The frame FSM states, the prefix bytes, the error-bit positions and the event width.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam int unsigned ERR_PARITY  = 0;
    localparam int unsigned ERR_FRAME   = 1;
    localparam int unsigned ERR_TIMEOUT = 2;
    localparam int unsigned ERR_OVF     = 3;

    localparam int unsigned PS2_EVT_W = 10;

    // Odd parity: the data bits plus the parity bit must carry an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Parameterised synchronous first-word-fall-through FIFO for decoded key events.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ps2_event_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign level   = count;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receive controller: pin synchroniser, frame FSM with watchdog,
// E0/F0 prefix folding and an event FIFO for the CPU-side bus logic.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic                          rd_valid,
    output logic [9:0]                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic [3:0]                    err
);
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES);

    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             clk_prev;
    logic             fe;
    logic             data_q;
    ps2_state_e       state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             par_bit;
    logic [WDW-1:0]   wd_cnt;
    logic             wd_exp;
    logic             ext_pend;
    logic             brk_pend;
    logic             stop_evt;
    logic             par_fail;
    logic             frame_fail;
    logic             good_byte;
    logic             is_prefix;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [3:0]       err_set;

    // Edge and data are registered together so data is sampled in the fe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
            fe        <= 1'b0;
            data_q    <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
            clk_prev  <= clk_sync[1];
            fe        <= clk_prev & ~clk_sync[1];
            data_q    <= data_sync[1];
        end
    end

    assign wd_exp     = (state != ST_IDLE) && !fe && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
    assign stop_evt   = fe && (state == ST_STOP);
    assign par_fail   = stop_evt && !ps2_parity_ok(shift, par_bit);
    assign frame_fail = stop_evt && ps2_parity_ok(shift, par_bit) && !data_q;
    assign good_byte  = stop_evt && ps2_parity_ok(shift, par_bit) && data_q;
    assign is_prefix  = (shift == PS2_PREFIX_EXT) || (shift == PS2_PREFIX_BRK);
    assign push       = good_byte && !is_prefix;
    assign pop        = rd_en && !fifo_empty;

    always_comb begin
        err_set              = '0;
        err_set[ERR_PARITY]  = par_fail;
        err_set[ERR_FRAME]   = frame_fail;
        err_set[ERR_TIMEOUT] = wd_exp;
        err_set[ERR_OVF]     = push && fifo_full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else if (wd_exp) begin
            state <= ST_IDLE;
        end else if (fe) begin
            case (state)
                ST_IDLE: begin
                    if (!data_q) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    shift   <= {data_q, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= ST_PARITY;
                end
                ST_PARITY: begin
                    par_bit <= data_q;
                    state   <= ST_STOP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (fe || state == ST_IDLE) begin
            wd_cnt <= '0;
        end else if (!wd_exp) begin
            wd_cnt <= wd_cnt + WDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (par_fail || frame_fail || wd_exp || push) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (good_byte) begin
            if (shift == PS2_PREFIX_EXT) ext_pend <= 1'b1;
            if (shift == PS2_PREFIX_BRK) brk_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= '0;
        end else begin
            err <= (err & ~{4{err_clr}}) | err_set;
        end
    end

    ps2_event_fifo #(
        .WIDTH (PS2_EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({ext_pend, brk_pend, shift}),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign rd_valid = !fifo_empty;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed bench for ps2_rx_ctrl: bit-banged PS/2 frames, a queue of expected
// events filled as frames are sent and drained as the FIFO is read.
module tb_ps2_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       rd_en;
    logic       err_clr;
    logic       rd_valid;
    logic [9:0] rd_data;
    logic [2:0] fifo_level;
    logic       busy;
    logic [3:0] err;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [9:0] exp_q[$];
    logic       m_ext;
    logic       m_brk;
    logic [3:0] exp_err;

    always #5 clk = ~clk;

    ps2_rx_ctrl #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .fifo_level (fifo_level),
        .busy       (busy),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One PS/2 bit: data set up during clock-high half, clock low for 20 clk.
    task automatic send_bit(input logic b, input bit lat_chk);
        ps2_data_i = b;
        repeat (20) @(negedge clk);
        ps2_clk_i = 1'b0;
        if (lat_chk) begin
            repeat (3) @(posedge clk);
            #1 chk("rd_valid_before_write", {31'd0, rd_valid}, 32'd0);
            @(posedge clk);
            #1 chk("rd_valid_latency", {31'd0, rd_valid}, 32'd1);
            repeat (16) @(negedge clk);
        end else begin
            repeat (20) @(negedge clk);
        end
        ps2_clk_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit lat_chk);
        logic par;
        par = ~^b ^ bad_par;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
        send_bit(par, 1'b0);
        send_bit(~bad_stop, lat_chk);
        ps2_data_i = 1'b1;
        repeat (40) @(negedge clk);
        if (bad_par) begin
            exp_err[0] = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
        end else if (bad_stop) begin
            exp_err[1] = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() < 4) exp_q.push_back({m_ext, m_brk, b});
            else exp_err[3] = 1'b1;
            m_ext = 1'b0; m_brk = 1'b0;
        end
        chk("busy_after_frame", {31'd0, busy}, 32'd0);
        chk("err_after_frame", {28'd0, err}, {28'd0, exp_err});
        chk("level_after_frame", {29'd0, fifo_level}, exp_q.size());
    endtask

    task automatic read_check();
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            chk("read_underflow_model", {31'd0, rd_valid}, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("rd_valid_head", {31'd0, rd_valid}, 32'd1);
            chk("rd_data_head", {22'd0, rd_data}, {22'd0, e});
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            chk("level_after_pop", {29'd0, fifo_level}, exp_q.size());
        end
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = '0;
        chk("err_cleared", {28'd0, err}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; ps2_clk_i = 1'b1; ps2_data_i = 1'b1;
        rd_en = 1'b0; err_clr = 1'b0;
        m_ext = 1'b0; m_brk = 1'b0; exp_err = '0;
        repeat (5) @(negedge clk);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", {22'd0, rd_data}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {28'd0, err}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Plain make code with the one-cycle write latency measured.
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
        read_check();

        // Break and extended-break prefixes fold into one event.
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        read_check();
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        read_check();

        // Parity error discards the byte; the next good byte still lands.
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        read_check();
        pulse_err_clr();

        // Abandoned partial frame trips the watchdog.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        chk("busy_mid_frame", {31'd0, busy}, 32'd1);
        repeat (250) @(negedge clk);
        exp_err[2] = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
        chk("busy_after_timeout", {31'd0, busy}, 32'd0);
        chk("err_timeout", {28'd0, err}, {28'd0, exp_err});
        chk("level_after_timeout", {29'd0, fifo_level}, 32'd0);

        // Frame error drops the pending E0.
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h42, 1'b0, 1'b1, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        read_check();
        pulse_err_clr();

        // Overflow: five events into a four-entry FIFO.
        send_frame(8'h15, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0, 1'b0);
        send_frame(8'h24, 1'b0, 1'b0, 1'b0);
        send_frame(8'h2D, 1'b0, 1'b0, 1'b0);
        send_frame(8'h2C, 1'b0, 1'b0, 1'b0);
        chk("level_full", {29'd0, fifo_level}, 32'd4);
        for (int i = 0; i < 4; i++) read_check();
        chk("rd_valid_drained", {31'd0, rd_valid}, 32'd0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("level_pop_empty", {29'd0, fifo_level}, 32'd0);
        pulse_err_clr();

        // Reset mid-frame with entries queued.
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("mid_rst_rd_data", {22'd0, rd_data}, 32'd0);
        chk("mid_rst_level", {29'd0, fifo_level}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_err", {28'd0, err}, 32'd0);
        exp_q.delete();
        m_ext = 1'b0; m_brk = 1'b0; exp_err = '0;
        ps2_data_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        read_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_rx_ctrl.md
# ps2_rx_ctrl

PS/2 keyboard receive controller for the 68k keyboard path. It synchronises the raw PS/2 clock and data pins into the system clock domain and detects PS/2 clock falling edges. It sequences 11-bit frame reception with odd-parity and stop checks plus an inactivity watchdog, folds E0/F0 prefix bytes into flags, and buffers complete key events in a small first-word-fall-through FIFO read by the CPU-side bus logic.

## Interface
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of two, ≥2.
- `TIMEOUT_CYCLES`, default 20000: clk cycles without a PS/2 falling edge before a partial frame is abandoned (2 ms at 10 MHz).
- `clk` input 1: system clock. All logic runs on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ps2_clk_i` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_data_i` input 1: raw PS/2 data pin, asynchronous.
- `rd_en` input 1: pops the FIFO head when `rd_valid`=1.
- `err_clr` input 1: one-cycle pulse that clears all sticky error bits.
- `rd_valid` output 1: FIFO not empty.
- `rd_data` output 10: FIFO head `{ext, brk, code[7:0]}`.
- `fifo_level` output clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `busy` output 1: frame FSM not in IDLE.
- `err` output 4: sticky flags `{ovf, timeout, frame, parity}`.

## Operation
- Synchroniser: two flops per pin, reset to 1. A falling edge (`fe`) is synced clock previous=1, current=0. Data is sampled from the synced data bit in the `fe` cycle.
- FSM states IDLE, DATA, PARITY, STOP. The FSM advances only on `fe`, except for the timeout.
  - IDLE: `fe` with data=0 → DATA, bit_cnt=0. `fe` with data=1 is ignored and sets no error.
  - DATA: shifts in data LSB first. After the 8th bit → PARITY.
  - PARITY: records the parity bit → STOP.
  - STOP: → IDLE in all cases. The byte is good only if (data bits + parity) has an odd count of ones and stop=1.
- Error priority at STOP: a parity failure sets `err[0]`. Otherwise, stop=0 sets `err[1]`. A bad frame is discarded.
- Watchdog: the counter clears on every `fe` and in IDLE. In any non-IDLE state, reaching TIMEOUT_CYCLES-1 forces IDLE and sets `err[2]`. Watchdog expiry and `fe` in the same cycle: `fe` wins.
- Prefix folding on a good byte:
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte pushes `{ext_pend, brk_pend, byte}` and clears both pendings.
  - Any error (parity, frame, timeout) also clears both pendings.
- FIFO is synchronous and first-word-fall-through.
  - A push while full with no pop drops the event, sets `err[3]`, and still clears the pendings.
  - A push and pop in the same cycle while full succeeds with no overflow.
  - A push and pop in the same cycle while empty is not possible, because the pop requires `rd_valid`.
  - `rd_en` while empty is ignored.
- `err`: each bit is sticky until `err_clr`. If a set and `err_clr` occur in the same cycle, the set wins.
- Reset mid-frame: FSM, pendings, FIFO and errors all clear immediately. The partial frame is lost.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `fifo_level`=0, `busy`=0, `err`=0.
- Pin to `fe`: 2 clk synchroniser latency plus 1 clk for the edge register.
- Stop-bit `fe` cycle: the FIFO write is registered at the end of this cycle. `rd_valid`=1 and `rd_data` are valid on the next cycle, 1 clk latency.
- Pop: `rd_data` shows the next entry, and `fifo_level` decrements, on the cycle after `rd_en`.
- `busy` rises the cycle after the start-bit `fe` and falls the cycle after the stop `fe` or the timeout.

## Structure
- Package `ps2_pkg` holds:
  - the FSM state enum;
  - `PS2_PREFIX_EXT`=8'hE0 and `PS2_PREFIX_BRK`=8'hF0;
  - the error-bit index constants `ERR_PARITY`=0, `ERR_FRAME`=1, `ERR_TIMEOUT`=2, `ERR_OVF`=3;
  - the event width, 10.
- Sub-module `ps2_event_fifo` is a parameterised synchronous FWFT FIFO (width, depth) with push, pop, full, empty and level ports. The synchroniser, FSM, watchdog and prefix logic stay in `ps2_rx_ctrl`.

## Test plan
Bench setup: TIMEOUT_CYCLES=200, PS/2 bit period 40 clk.
- Make code 0x1C, parity 0, stop 1 → one entry `{0,0,0x1C}`; `rd_valid`=1 one clk after the stop `fe`; `err`=0.
- Frames F0 then 0x1C → single entry `{0,1,0x1C}`. Frames E0, F0, 0x75 → `{1,1,0x75}`. `fifo_level`=1 in each case.
- 0x1C sent with parity 1 → no entry, `err`=4'b0001. Next a good 0x1C → entry accepted. Then `err_clr` → `err`=0.
- Start bit plus 3 data bits, then idle 200 clk → `busy` falls, `err[2]`=1, no entry. Then E0 and a bad-stop frame, then 0x75 → `{0,0,0x75}`, because the frame error cleared ext_pend.
- Five make codes with no reads (FIFO_DEPTH=4) → `fifo_level`=4 and `err[3]`=1. The first four codes read back in order, and `rd_valid` drops after the 4th pop.
- Assert `rst_n` low mid-DATA with two entries queued → all outputs 0 immediately. After release, a clean 0x1C frame is received correctly.
